// File: rtl/comproc_pkg.sv
// Shared types for the boot loader / CPU bus arbiter.
package comproc_pkg;

  typedef enum logic [2:0] {
    LEN_LO,
    LEN_HI,
    DATA_LO,
    DATA_HI,
    WRITE,
    RUN,
    ERR
  } loader_state_t;

  localparam int IMG_LEN_W = 16;

endpackage

// File: rtl/rx_timeout.sv
// Inter-byte idle watchdog: reloads on every kick, pulses expire once the
// enabled countdown reaches zero without a kick.
module rx_timeout #(
  parameter int TIMEOUT = 27000000
) (
  input  logic clk,
  input  logic rst,
  input  logic kick,
  input  logic en,
  output logic expire
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt;

  // Held at the reload value whenever disabled so each armed state starts fresh.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= RELOAD;
    end else if (kick || !en) begin
      cnt <= RELOAD;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expire = en && !kick && (cnt == '0);

endmodule

// File: rtl/boot_loader_arbiter.sv
// Loads a length-prefixed UART image into BRAM while holding the CPU in reset,
// then hands the memory bus to the CPU for good.
module boot_loader_arbiter
  import comproc_pkg::*;
#(
  parameter int               ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int               MAX_WORDS = 2048,
  parameter int               TIMEOUT   = 27000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_wr,
  input  logic              cpu_byt,
  input  logic [15:0]       cpu_wr_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr,
  output logic              mem_byt,
  output logic [15:0]       mem_wr_data,
  output logic              cpu_rst,
  output logic              load_busy,
  output logic              load_err
);

  loader_state_t state, next_state;

  logic [7:0]           len_lo;
  logic [7:0]           lo_byte;
  logic [IMG_LEN_W-1:0] len;
  logic [IMG_LEN_W-1:0] count;
  logic [ADDR_W-1:0]    load_addr;
  logic [ADDR_W-1:0]    wr_addr;
  logic [15:0]          wr_word;

  logic [IMG_LEN_W-1:0] rx_len;
  logic                 last_word;
  logic                 timer_en;
  logic                 expire;

  assign rx_len    = {rx_data, len_lo};
  assign last_word = (count + IMG_LEN_W'(1)) == len;
  assign timer_en  = (state == LEN_HI) || (state == DATA_LO) || (state == DATA_HI);

  rx_timeout #(.TIMEOUT(TIMEOUT)) u_rx_timeout (
    .clk    (clk),
    .rst    (rst),
    .kick   (rx_valid),
    .en     (timer_en),
    .expire (expire)
  );

  always_comb begin
    next_state = state;
    case (state)
      LEN_LO:  if (rx_valid) next_state = LEN_HI;
      LEN_HI: begin
        if (rx_valid) begin
          if (rx_len == '0)                   next_state = RUN;
          else if (int'(rx_len) > MAX_WORDS)  next_state = ERR;
          else                                next_state = DATA_LO;
        end else if (expire) begin
          next_state = LEN_LO;
        end
      end
      DATA_LO: begin
        if (rx_valid)    next_state = DATA_HI;
        else if (expire) next_state = LEN_LO;
      end
      DATA_HI: begin
        if (rx_valid)    next_state = WRITE;
        else if (expire) next_state = LEN_LO;
      end
      // A byte landing during the write slot is the next word's low byte.
      WRITE: begin
        if (last_word)     next_state = RUN;
        else if (rx_valid) next_state = DATA_HI;
        else               next_state = DATA_LO;
      end
      default: next_state = state;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= LEN_LO;
      cpu_rst   <= 1'b1;
      load_busy <= 1'b0;
      load_err  <= 1'b0;
      len_lo    <= '0;
      lo_byte   <= '0;
      len       <= '0;
      count     <= '0;
      load_addr <= BASE_ADDR;
      wr_addr   <= BASE_ADDR;
      wr_word   <= '0;
    end else begin
      state     <= next_state;
      cpu_rst   <= (next_state != RUN);
      load_busy <= (next_state == DATA_LO) || (next_state == DATA_HI) || (next_state == WRITE);
      load_err  <= (next_state == ERR);
      case (state)
        LEN_LO:  if (rx_valid) len_lo <= rx_data;
        LEN_HI:  if (rx_valid) len <= rx_len;
        DATA_LO: if (rx_valid) lo_byte <= rx_data;
        DATA_HI: begin
          if (rx_valid) begin
            wr_word <= {rx_data, lo_byte};
            wr_addr <= load_addr;
          end
        end
        WRITE: begin
          load_addr <= load_addr + ADDR_W'(2);
          count     <= count + IMG_LEN_W'(1);
          if (rx_valid) lo_byte <= rx_data;
        end
        default: ;
      endcase
      // An aborted load restarts from the base; written words stay in BRAM.
      if (expire) begin
        load_addr <= BASE_ADDR;
        count     <= '0;
      end
    end
  end

  always_comb begin
    if (state == RUN) begin
      mem_addr    = cpu_addr;
      mem_wr      = cpu_wr;
      mem_byt     = cpu_byt;
      mem_wr_data = cpu_wr_data;
    end else begin
      mem_addr    = wr_addr;
      mem_wr      = (state == WRITE);
      mem_byt     = 1'b0;
      mem_wr_data = wr_word;
    end
  end

endmodule

// File: tb/tb_boot_loader_arbiter.sv
// Self-checking bench for boot_loader_arbiter: random images checked against a
// byte-stream model of the loader protocol.
module tb_boot_loader_arbiter;

  localparam int ADDR_W = 16;
  localparam int MAX_WORDS = 2048;
  localparam int TIMEOUT = 50;
  localparam logic [ADDR_W-1:0] BASE_ADDR = 16'h0000;

  typedef logic [7:0] byte_q_t[$];

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [7:0]        rx_data = '0;
  logic              rx_valid = 1'b0;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic              cpu_wr = 1'b0;
  logic              cpu_byt = 1'b0;
  logic [15:0]       cpu_wr_data = '0;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wr;
  logic              mem_byt;
  logic [15:0]       mem_wr_data;
  logic              cpu_rst;
  logic              load_busy;
  logic              load_err;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  boot_loader_arbiter #(
    .ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR), .MAX_WORDS(MAX_WORDS), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .cpu_addr(cpu_addr), .cpu_wr(cpu_wr), .cpu_byt(cpu_byt), .cpu_wr_data(cpu_wr_data),
    .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_byt(mem_byt), .mem_wr_data(mem_wr_data),
    .cpu_rst(cpu_rst), .load_busy(load_busy), .load_err(load_err)
  );

  // Bus observer: loader writes, stray writes in RUN, cpu_rst release cycle.
  logic [ADDR_W-1:0] got_addr[$];
  logic [15:0]       got_data[$];
  logic              got_byt[$];
  int cycle = 0;
  int last_wr_cycle = -1;
  int rst_fall_cycle = -1;
  int stray_wr = 0;
  bit busy_seen = 0;
  logic prev_cpu_rst = 1'b1;

  always @(posedge clk) cycle++;

  always @(negedge clk) begin
    if (mem_wr && cpu_rst) begin
      got_addr.push_back(mem_addr);
      got_data.push_back(mem_wr_data);
      got_byt.push_back(mem_byt);
      last_wr_cycle = cycle;
    end
    if (mem_wr && !cpu_rst && !cpu_wr) stray_wr++;
    if (prev_cpu_rst && !cpu_rst) rst_fall_cycle = cycle;
    if (load_busy) busy_seen = 1;
    prev_cpu_rst = cpu_rst;
  end

  // Reference model: word i of an image lands at BASE+2i as {hi, lo}.
  function automatic logic [15:0] exp_data(input byte_q_t img, input int i);
    return {img[3 + 2*i], img[2 + 2*i]};
  endfunction

  function automatic logic [ADDR_W-1:0] exp_addr(input int i);
    return BASE_ADDR + ADDR_W'(2 * i);
  endfunction

  function automatic byte_q_t make_image(input int n);
    byte_q_t q;
    logic [15:0] len;
    len = 16'(n);
    q.push_back(len[7:0]);
    q.push_back(len[15:8]);
    for (int i = 0; i < 2 * n; i++) q.push_back(8'($urandom_range(255, 0)));
    return q;
  endfunction

  task automatic apply_reset();
    rst = 1'b1;
    rx_valid = 1'b0;
    cpu_wr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    got_addr.delete();
    got_data.delete();
    got_byt.delete();
    last_wr_cycle = -1;
    rst_fall_cycle = -1;
    stray_wr = 0;
    busy_seen = 0;
  endtask

  // Starts and ends on a negedge; gaps of 0 give back-to-back strobes.
  task automatic send_bytes(input byte_q_t bytes, input int max_gap);
    int g;
    for (int i = 0; i < bytes.size(); i++) begin
      rx_data = bytes[i];
      rx_valid = 1'b1;
      @(negedge clk);
      g = $urandom_range(max_gap, 0);
      if (g > 0) begin
        rx_valid = 1'b0;
        repeat (g) @(negedge clk);
      end
    end
    rx_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    tests_run++;
    if (cpu_rst !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_cpu_rst: got %b expected 1", cpu_rst); end
    tests_run++;
    if (mem_wr !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_mem_wr: got %b expected 0", mem_wr); end
    tests_run++;
    if (load_busy !== 1'b0 || load_err !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL reset_flags: busy=%b err=%b expected 0 0", load_busy, load_err);
    end
    tests_run++;
    if (mem_addr !== BASE_ADDR) begin tests_failed++; $display("[TB] FAIL reset_mem_addr: got %h expected %h", mem_addr, BASE_ADDR); end
    apply_reset();
    repeat (80) @(negedge clk);
    tests_run++;
    if (cpu_rst !== 1'b1 || load_busy !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL idle_len_lo: cpu_rst=%b busy=%b expected 1 0", cpu_rst, load_busy);
    end
  endtask

  task automatic test_basic_image();
    byte_q_t img;
    logic [ADDR_W-1:0] a;
    logic [15:0] d;
    logic b;
    img = '{8'h03, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56, 8'hBC, 8'h9A};
    apply_reset();
    send_bytes(img, 2);
    repeat (3) @(negedge clk);
    #1;
    tests_run++;
    if (got_addr.size() != 3) begin tests_failed++; $display("[TB] FAIL basic_count: got %0d writes expected 3", got_addr.size()); end
    for (int i = 0; i < 3 && i < got_addr.size(); i++) begin
      tests_run++;
      if (got_addr[i] !== exp_addr(i) || got_data[i] !== exp_data(img, i) || got_byt[i] !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL basic_word%0d: got %h@%h byt=%b expected %h@%h byt=0", i, got_data[i], got_addr[i], got_byt[i], exp_data(img, i), exp_addr(i));
      end
    end
    tests_run++;
    if (rst_fall_cycle != last_wr_cycle + 1) begin
      tests_failed++; $display("[TB] FAIL basic_cpu_rst_fall: got cycle %0d expected %0d", rst_fall_cycle, last_wr_cycle + 1);
    end
    tests_run++;
    if (cpu_rst !== 1'b0 || load_busy !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL basic_run_flags: cpu_rst=%b busy=%b expected 0 0", cpu_rst, load_busy);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #2;
      a = ADDR_W'($urandom);
      d = 16'($urandom);
      b = 1'($urandom);
      cpu_addr = a; cpu_wr_data = d; cpu_byt = b; cpu_wr = 1'b1;
      #1;
      tests_run++;
      if (mem_addr !== a || mem_wr_data !== d || mem_byt !== b || mem_wr !== 1'b1) begin
        tests_failed++;
        $display("[TB] FAIL run_mirror%0d: got %h/%h/%b/%b expected %h/%h/%b/1", k, mem_addr, mem_wr_data, mem_byt, mem_wr, a, d, b);
      end
      cpu_wr = 1'b0;
    end
  endtask

  task automatic test_zero_length();
    apply_reset();
    send_bytes('{8'h00, 8'h00}, 0);
    tests_run++;
    if (cpu_rst !== 1'b0) begin tests_failed++; $display("[TB] FAIL zero_cpu_rst: got %b expected 0", cpu_rst); end
    repeat (5) @(negedge clk);
    #1;
    tests_run++;
    if (got_addr.size() != 0 || busy_seen) begin
      tests_failed++; $display("[TB] FAIL zero_activity: got %0d writes busy_seen=%0d expected 0 0", got_addr.size(), busy_seen);
    end
  endtask

  task automatic test_length_limit();
    byte_q_t junk;
    apply_reset();
    send_bytes('{8'h00, 8'h08}, 0);
    @(negedge clk);
    tests_run++;
    if (load_busy !== 1'b1 || load_err !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL len_2048_accept: busy=%b err=%b expected 1 0", load_busy, load_err);
    end
    apply_reset();
    send_bytes('{8'h01, 8'h08}, 0);
    @(negedge clk);
    tests_run++;
    if (load_err !== 1'b1 || cpu_rst !== 1'b1 || load_busy !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL len_2049_err: err=%b cpu_rst=%b busy=%b expected 1 1 0", load_err, cpu_rst, load_busy);
    end
    for (int i = 0; i < 12; i++) junk.push_back(8'($urandom_range(255, 0)));
    send_bytes(junk, 1);
    repeat (TIMEOUT + 10) @(negedge clk);
    #1;
    tests_run++;
    if (got_addr.size() != 0 || load_err !== 1'b1 || cpu_rst !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL err_sticky: writes=%0d err=%b cpu_rst=%b expected 0 1 1", got_addr.size(), load_err, cpu_rst);
    end
  endtask

  task automatic test_timeout();
    apply_reset();
    send_bytes('{8'h02, 8'h00, 8'h34, 8'h12, 8'h78}, 0);
    repeat (40) @(negedge clk);
    tests_run++;
    if (load_busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL timeout_early: busy=%b expected 1", load_busy); end
    repeat (20) @(negedge clk);
    tests_run++;
    if (load_busy !== 1'b0 || cpu_rst !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL timeout_abort: busy=%b cpu_rst=%b expected 0 1", load_busy, cpu_rst);
    end
    tests_run++;
    if (got_addr.size() != 1 || got_data[0] !== 16'h1234 || got_addr[0] !== BASE_ADDR) begin
      tests_failed++; $display("[TB] FAIL timeout_partial: got %0d writes expected 1 (1234@%h)", got_addr.size(), BASE_ADDR);
    end
    send_bytes('{8'h01, 8'h00, 8'hCD, 8'hAB}, 1);
    repeat (3) @(negedge clk);
    #1;
    tests_run++;
    if (got_addr.size() != 2 || got_data[1] !== 16'hABCD || got_addr[1] !== BASE_ADDR || cpu_rst !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL timeout_reload: writes=%0d cpu_rst=%b expected 2 writes, ABCD@%h, cpu_rst 0", got_addr.size(), cpu_rst, BASE_ADDR);
    end
  endtask

  task automatic test_reset_mid_load();
    byte_q_t img;
    apply_reset();
    send_bytes('{8'h02, 8'h00, 8'h11, 8'h22}, 0);
    #2;
    rst = 1'b1;
    #1;
    tests_run++;
    if (mem_wr !== 1'b0 || cpu_rst !== 1'b1 || load_busy !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL async_reset: mem_wr=%b cpu_rst=%b busy=%b expected 0 1 0", mem_wr, cpu_rst, load_busy);
    end
    tests_run++;
    if (got_addr.size() != 1 || got_data[0] !== 16'h2211) begin
      tests_failed++; $display("[TB] FAIL prereset_write: got %0d writes expected 1 (2211)", got_addr.size());
    end
    apply_reset();
    img = make_image(2);
    send_bytes(img, 2);
    repeat (3) @(negedge clk);
    #1;
    tests_run++;
    if (got_addr.size() != 2) begin tests_failed++; $display("[TB] FAIL reload_count: got %0d expected 2", got_addr.size()); end
    for (int i = 0; i < 2 && i < got_addr.size(); i++) begin
      tests_run++;
      if (got_addr[i] !== exp_addr(i) || got_data[i] !== exp_data(img, i)) begin
        tests_failed++; $display("[TB] FAIL reload_word%0d: got %h@%h expected %h@%h", i, got_data[i], got_addr[i], exp_data(img, i), exp_addr(i));
      end
    end
  endtask

  task automatic test_back_to_back();
    byte_q_t img;
    byte_q_t junk;
    int n;
    for (int it = 0; it < 5; it++) begin
      n = $urandom_range(8, 1);
      img = make_image(n);
      apply_reset();
      send_bytes(img, (it < 2) ? 0 : 3);
      junk.delete();
      for (int i = 0; i < 6; i++) junk.push_back(8'($urandom_range(255, 0)));
      send_bytes(junk, 1);
      repeat (3) @(negedge clk);
      #1;
      tests_run++;
      if (got_addr.size() != n) begin tests_failed++; $display("[TB] FAIL b2b%0d_count: got %0d expected %0d", it, got_addr.size(), n); end
      for (int i = 0; i < n && i < got_addr.size(); i++) begin
        tests_run++;
        if (got_addr[i] !== exp_addr(i) || got_data[i] !== exp_data(img, i)) begin
          tests_failed++; $display("[TB] FAIL b2b%0d_word%0d: got %h@%h expected %h@%h", it, i, got_data[i], got_addr[i], exp_data(img, i), exp_addr(i));
        end
      end
      tests_run++;
      if (stray_wr != 0 || cpu_rst !== 1'b0) begin
        tests_failed++; $display("[TB] FAIL b2b%0d_run_quiet: stray=%0d cpu_rst=%b expected 0 0", it, stray_wr, cpu_rst);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_image();
    test_zero_length();
    test_length_limit();
    test_timeout();
    test_reset_mid_load();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
